// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/cmos_full_subtractor.sv
// 1-bit full-subtractor cell: Diff = A - B - Bin (one bit), Bout = borrow out.
module cmos_full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// through a single full-subtractor cell. diff/bout only change when a full
// result is ready, so callers never see partial sums.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_res_next;

    assign w_x = r_a[r_cnt];
    assign w_y = r_b[r_cnt];

    cmos_full_subtractor u_cell (
        .A    (w_x),
        .B    (w_y),
        .Bin  (r_br),
        .Diff (w_d),
        .Bout (w_bo)
    );

    // Partial result with the current bit merged in; on the last bit this is the full answer.
    always_comb begin
        w_res_next        = r_res;
        w_res_next[r_cnt] = w_d;
    end

    // Control FSM with operand capture, bit counter, borrow chain and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // start is deliberately not looked at here: the op in flight owns the datapath
                    r_res <= w_res_next;
                    r_br  <= w_bo;
                    if (r_cnt == LAST) begin
                        // counter parks at 0 so it never runs past WIDTH-1
                        r_cnt   <= '0;
                        r_diff  <= w_res_next;
                        r_bout  <= w_bo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // back-to-back: next op begins without an IDLE bubble
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench: WIDTH=8 directed + random ops, reset abort, back-to-back,
// and an exhaustive WIDTH=4 sweep, all against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int checks = 0;
    int failures = 0;

    serial_subtractor_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    // Reference: {borrow, diff} of a - b - bin at width w, from plain integer arithmetic.
    function automatic logic [8:0] model(input int w, input int ai, input int bi, input int ci);
        int r;
        int m;
        m = (1 << w) - 1;
        r = (ai - bi - ci) & m;
        return {(ai < bi + ci) ? 1'b1 : 1'b0, 8'(r)};
    endfunction

    // Drives one WIDTH=8 op and reports what was observed; callers do the checks.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input bit hold,
                        output int nbusy, output bit got, output logic [7:0] d, output logic bo,
                        output bit partial, output bit overlap);
        logic [7:0] pd;
        logic       pbo;
        pd = diff; pbo = bout;
        nbusy = 0; got = 0; partial = 0; overlap = 0;
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(posedge clk); #1;
        start = hold;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (busy && done) overlap = 1;
            if (done) begin got = 1; break; end
            if (busy) nbusy++;
            if (diff !== pd || bout !== pbo) partial = 1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        d = diff; bo = bout;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            failures++; $display("FAIL reset_w8 got busy=%b done=%b diff=%h bout=%b expected all 0", busy, done, diff, bout);
        end
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'd0) begin
            failures++; $display("FAIL reset_w4 got busy=%b done=%b diff=%h bout=%b expected all 0", busy4, done4, diff4, bout4);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [7:0] ta[3], tb_[3];
        logic       tc[3];
        logic [8:0] exp;
        int nb; bit got, part, ovl; logic [7:0] d; logic bo;
        ta[0] = 8'h05; tb_[0] = 8'h03; tc[0] = 1'b0;
        ta[1] = 8'h03; tb_[1] = 8'h05; tc[1] = 1'b0;
        ta[2] = 8'h00; tb_[2] = 8'h00; tc[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = model(8, int'(ta[k]), int'(tb_[k]), int'(tc[k]));
            run8(ta[k], tb_[k], tc[k], 1'b0, nb, got, d, bo, part, ovl);
            checks++;
            if (!got || nb != 8) begin
                failures++; $display("FAIL directed%0d_latency got done=%0d busy_cycles=%0d expected done=1 busy_cycles=8", k, got, nb);
            end
            checks++;
            if ({bo, d} !== exp) begin
                failures++; $display("FAIL directed%0d_result got bout=%b diff=%h expected bout=%b diff=%h", k, bo, d, exp[8], exp[7:0]);
            end
            checks++;
            if (part || ovl) begin
                failures++; $display("FAIL directed%0d_outputs got partial=%0d overlap=%0d expected 0 0", k, part, ovl);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL directed%0d_pulse got busy=%b done=%b expected 0 0", k, busy, done);
            end
        end
    endtask

    task automatic test_start_held;
        int nb; bit got, part, ovl; logic [7:0] d; logic bo;
        run8(8'hFF, 8'hFF, 1'b0, 1'b1, nb, got, d, bo, part, ovl);
        checks++;
        if (!got || nb != 8 || {bo, d} !== 9'h000) begin
            failures++; $display("FAIL start_held got done=%0d busy_cycles=%0d bout=%b diff=%h expected 1 8 0 00", got, nb, bo, d);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL start_held_single got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        int nb; bit got, part, ovl; bit seen_done; logic [7:0] d; logic bo;
        start = 1'b1; a = 8'hA5; b = 8'h3C; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            failures++; $display("FAIL reset_abort got busy=%b done=%b diff=%h bout=%b expected all 0", busy, done, diff, bout);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen_done = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_done) begin
            failures++; $display("FAIL reset_no_done got activity=1 expected 0");
        end
        run8(8'h10, 8'h01, 1'b0, 1'b0, nb, got, d, bo, part, ovl);
        checks++;
        if (!got || nb != 8 || {bo, d} !== 9'h00F) begin
            failures++; $display("FAIL reset_restart got done=%0d busy_cycles=%0d bout=%b diff=%h expected 1 8 0 0f", got, nb, bo, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] a1, b1, a2, b2;
        logic       c1, c2;
        logic [8:0] e1, e2;
        int nb; bit got, held_ok;
        a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
        a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
        e1 = model(8, int'(a1), int'(b1), int'(c1));
        e2 = model(8, int'(a2), int'(b2), int'(c2));
        start = 1'b1; a = a1; b = b1; bin = c1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin got = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!got || {bout, diff} !== e1) begin
            failures++; $display("FAIL b2b_first got done=%0d bout=%b diff=%h expected 1 %b %h", got, bout, diff, e1[8], e1[7:0]);
        end
        start = 1'b1; a = a2; b = b2; bin = c2;
        @(posedge clk); #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL b2b_restart got busy=%b done=%b expected 1 0", busy, done);
        end
        nb = 0; got = 0; held_ok = 1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin got = 1; break; end
            if (busy) nb++;
            if ({bout, diff} !== e1) held_ok = 0;
            @(posedge clk); #1;
        end
        checks++;
        if (!held_ok) begin
            failures++; $display("FAIL b2b_hold got first_result_held=0 expected 1");
        end
        checks++;
        if (!got || nb != 8 || {bout, diff} !== e2) begin
            failures++; $display("FAIL b2b_second got done=%0d busy_cycles=%0d bout=%b diff=%h expected 1 8 %b %h", got, nb, bout, diff, e2[8], e2[7:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [7:0] ra, rb, d;
        logic       rc, bo;
        logic [8:0] exp;
        int nb; bit got, part, ovl, hold;
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); hold = 1'($urandom);
            exp = model(8, int'(ra), int'(rb), int'(rc));
            run8(ra, rb, rc, hold, nb, got, d, bo, part, ovl);
            checks++;
            if (!got || nb != 8 || part || ovl || {bo, d} !== exp) begin
                failures++;
                $display("FAIL random%0d a=%h b=%h bin=%b got done=%0d busy_cycles=%0d partial=%0d overlap=%0d bout=%b diff=%h expected 1 8 0 0 %b %h",
                         k, ra, rb, rc, got, nb, part, ovl, bo, d, exp[8], exp[7:0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_width4_exhaustive;
        logic [8:0] exp;
        bit got;
        int nb;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp = model(4, ai, bi, ci);
                    start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci);
                    @(posedge clk); #1;
                    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
                    got = 0; nb = 0;
                    for (int i = 0; i < 12; i++) begin
                        if (done4) begin got = 1; break; end
                        if (busy4) nb++;
                        @(posedge clk); #1;
                    end
                    checks++;
                    if (!got || nb != 4 || {bout4, diff4} !== {exp[8], exp[3:0]}) begin
                        failures++;
                        $display("FAIL w4 a=%0d b=%0d bin=%0d got done=%0d busy_cycles=%0d bout=%b diff=%h expected 1 4 %b %h",
                                 ai, bi, ci, got, nb, bout4, diff4, exp[8], exp[3:0]);
                    end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_held();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_width4_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
